// File: rtl/sd_buf_arb_if.sv
// sd_buf_arb_if: requester, RAM command and status bundle of the buffer
// arbiter. slave = arbiter side, master = requesters + RAM side.
interface sd_buf_arb_if #(
  parameter int AW = 10,
  parameter int DW = 4
);
  logic          ireq0;
  logic          iwe0;
  logic [AW-1:0] iaddr0;
  logic [DW-1:0] idata0;
  logic          ogrant0;
  logic [DW-1:0] odata0;
  logic          ovalid0;

  logic          ireq1;
  logic          iwe1;
  logic [AW-1:0] iaddr1;
  logic [DW-1:0] idata1;
  logic          ogrant1;
  logic [DW-1:0] odata1;
  logic          ovalid1;

  logic          oram_en;
  logic          oram_we;
  logic [AW-1:0] oram_addr;
  logic [DW-1:0] oram_data;
  logic [DW-1:0] iram_data;
  logic          ostarve;

  modport slave (
    input  ireq0, iwe0, iaddr0, idata0,
    output ogrant0, odata0, ovalid0,
    input  ireq1, iwe1, iaddr1, idata1,
    output ogrant1, odata1, ovalid1,
    output oram_en, oram_we,
    output oram_addr, oram_data,
    input  iram_data,
    output ostarve
  );

  modport master (
    output ireq0, iwe0, iaddr0, idata0,
    input  ogrant0, odata0, ovalid0,
    output ireq1, iwe1, iaddr1, idata1,
    input  ogrant1, odata1, ovalid1,
    input  oram_en, oram_we,
    input  oram_addr, oram_data,
    output iram_data,
    input  ostarve
  );
endinterface

// File: rtl/sd_buf_arb.sv
// sd_buf_arb: two-port arbiter for the single-port SD block buffer RAM.
// Ports: iclk, irst (async high), bus (slave modport: req/grant/RAM).
module sd_buf_arb #(
  parameter int AW       = 10,
  parameter int DW       = 4,
  parameter int MAX_WAIT = 4
) (
  input  logic        iclk,
  input  logic        irst,
  sd_buf_arb_if.slave bus
);
  localparam logic [3:0] MW = 4'(MAX_WAIT);

  logic [3:0]    wait_q, wait_d;
  logic          starve_q, starve_d;
  logic          en_q, en_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  // read-tag pipe: [0] = RAM cmd stage, [1] = RAM data stage
  logic [1:0]    tv_q, tv_d;
  logic [1:0]    tid_q, tid_d;
  logic          ovr, g0, g1;

  always_comb begin
    ovr = bus.ireq1 & (wait_q == MW);
    // grants are forced low while reset is held
    g1  = ~irst & bus.ireq1 & (ovr | ~bus.ireq0);
    g0  = ~irst & bus.ireq0 & ~g1;

    wait_d = wait_q;
    if (!bus.ireq1 || g1) begin
      wait_d = '0;
    end else if (wait_q != MW) begin
      wait_d = wait_q + 4'd1;
    end

    // only a real override pulses: port 0 was asking too
    starve_d = ovr & bus.ireq0 & ~irst;

    en_d   = g0 | g1;
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    unique case (1'b1)
      g1: begin
        we_d   = bus.iwe1;
        addr_d = bus.iaddr1;
        data_d = bus.idata1;
      end
      g0: begin
        we_d   = bus.iwe0;
        addr_d = bus.iaddr0;
        data_d = bus.idata0;
      end
      default: ;
    endcase

    tv_d  = {tv_q[0], en_d & ~we_d};
    tid_d = {tid_q[0], g1};
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      wait_q   <= '0;
      starve_q <= 1'b0;
      en_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      tv_q     <= '0;
      tid_q    <= '0;
    end else begin
      wait_q   <= wait_d;
      starve_q <= starve_d;
      en_q     <= en_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      tv_q     <= tv_d;
      tid_q    <= tid_d;
    end
  end

  assign bus.ogrant0   = g0;
  assign bus.ogrant1   = g1;
  assign bus.ovalid0   = tv_q[1] & ~tid_q[1];
  assign bus.ovalid1   = tv_q[1] & tid_q[1];
  assign bus.odata0    = bus.ovalid0 ? bus.iram_data : '0;
  assign bus.odata1    = bus.ovalid1 ? bus.iram_data : '0;
  assign bus.oram_en   = en_q;
  assign bus.oram_we   = we_q;
  assign bus.oram_addr = addr_q;
  assign bus.oram_data = data_q;
  assign bus.ostarve   = starve_q;
endmodule

// File: tb/tb_sd_buf_arb.sv
// tb_sd_buf_arb: scoreboard bench for sd_buf_arb with a behavioural
// RAM, arbitration reference model and randomized requesters.
`timescale 1ns/100ps
module tb_sd_buf_arb;
  localparam int MW = 4;

  typedef struct {
    bit         idle;
    bit         we;
    logic [9:0] addr;
    logic [3:0] data;
    int         lim;
  } op_t;
  typedef struct {
    logic [3:0] d;
    int         cyc;
  } rd_t;
  typedef struct {
    logic       we;
    logic [9:0] addr;
    logic [3:0] data;
    int         cyc;
  } cmd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  sd_buf_arb_if #(.AW(10), .DW(4)) bus ();

  sd_buf_arb #(.AW(10), .DW(4), .MAX_WAIT(MW)) dut (
    .iclk (clk),
    .irst (rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // requester state
  logic       r_req  [2] = '{1'b0, 1'b0};
  logic       r_we   [2] = '{1'b0, 1'b0};
  logic [9:0] r_addr [2] = '{10'd0, 10'd0};
  logic [3:0] r_data [2] = '{4'd0, 4'd0};
  int         held   [2] = '{0, 0};
  int         lim    [2] = '{0, 0};
  bit         gl     [2] = '{1'b0, 1'b0};
  int         pct    [2] = '{0, 0};
  bit         rnd_on = 1'b0;

  op_t  pend0[$], pend1[$];
  rd_t  rdq0[$], rdq1[$];
  cmd_t cmdq[$];

  logic [3:0] ram   [1024];
  logic [3:0] mem_m [1024];
  logic [3:0] rdat = 4'd0;

  assign bus.ireq0     = r_req[0];
  assign bus.iwe0      = r_we[0];
  assign bus.iaddr0    = r_addr[0];
  assign bus.idata0    = r_data[0];
  assign bus.ireq1     = r_req[1];
  assign bus.iwe1      = r_we[1];
  assign bus.iaddr1    = r_addr[1];
  assign bus.idata1    = r_data[1];
  assign bus.iram_data = rdat;

  // synchronous single-port RAM
  always @(posedge clk) begin
    if (bus.oram_en) begin
      if (bus.oram_we) ram[bus.oram_addr] <= bus.oram_data;
      else rdat <= ram[bus.oram_addr];
    end
  end

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h cycle %0d",
               n, a, e, cyc);
    end
  endtask

  function automatic op_t mk(bit idle, bit we, int a, int d, int l);
    op_t o;
    o.idle = idle;
    o.we   = we;
    o.addr = 10'(a);
    o.data = 4'(d);
    o.lim  = l;
    return o;
  endfunction

  task automatic push_op(int p, op_t o);
    if (p == 0) pend0.push_back(o);
    else pend1.push_back(o);
  endtask

  // driver: hold each request until granted (or its hold limit)
  always @(posedge clk) begin
    op_t o;
    #1;
    if (!rst) begin
      for (int p = 0; p < 2; p++) begin
        bit have;
        if (gl[p]) begin
          r_req[p] = 1'b0;
        end else if (r_req[p]) begin
          held[p]++;
          if (lim[p] != 0 && held[p] >= lim[p]) r_req[p] = 1'b0;
        end
        if (!r_req[p]) begin
          have = (p == 0) ? pend0.size() > 0 : pend1.size() > 0;
          if (have) begin
            o = (p == 0) ? pend0.pop_front() : pend1.pop_front();
          end else if (rnd_on && $urandom_range(99) < pct[p]) begin
            o = mk(0, $urandom_range(1) == 1,
                   $urandom_range(15), $urandom_range(15), 0);
            have = 1'b1;
          end
          if (have && !o.idle) begin
            r_req[p]  = 1'b1;
            r_we[p]   = o.we;
            r_addr[p] = o.addr;
            r_data[p] = o.data;
            lim[p]    = o.lim;
            held[p]   = 0;
          end
        end
      end
    end
  end

  // reference model: priority + starvation rule, memory by grant order
  int streak = 0;
  bit exp_st = 1'b0;
  always @(posedge clk) begin
    bit ovr, e0, e1;
    int p;
    cmd_t c;
    rd_t  r;
    #2;
    if (rst) begin
      streak = 0;
      exp_st = 1'b0;
      gl[0]  = 1'b0;
      gl[1]  = 1'b0;
    end else begin
      chk("ostarve", bus.ostarve, exp_st);
      ovr = r_req[1] && streak >= MW;
      e1  = r_req[1] && (ovr || !r_req[0]);
      e0  = r_req[0] && !e1;
      chk("ogrant0", bus.ogrant0, e0);
      chk("ogrant1", bus.ogrant1, e1);
      exp_st = ovr && r_req[0];
      streak = (r_req[1] && !e1) ? streak + 1 : 0;
      if (e0 || e1) begin
        p      = e1 ? 1 : 0;
        c.we   = r_we[p];
        c.addr = r_addr[p];
        c.data = r_data[p];
        c.cyc  = cyc + 1;
        cmdq.push_back(c);
        if (r_we[p]) begin
          mem_m[r_addr[p]] = r_data[p];
        end else begin
          r.d   = mem_m[r_addr[p]];
          r.cyc = cyc + 2;
          if (p == 0) rdq0.push_back(r);
          else rdq1.push_back(r);
        end
      end
      gl[0] = e0;
      gl[1] = e1;
    end
  end

  task automatic mon_rd(int p, logic v, logic [3:0] d);
    rd_t e;
    int  n;
    n = (p == 0) ? rdq0.size() : rdq1.size();
    if (v) begin
      if (n == 0) begin
        chk($sformatf("ovalid%0d_unexpected", p), 1, 0);
      end else begin
        e = (p == 0) ? rdq0.pop_front() : rdq1.pop_front();
        chk($sformatf("ovalid%0d_cycle", p), cyc, e.cyc);
        chk($sformatf("odata%0d", p), d, e.d);
      end
    end else if (n > 0) begin
      e = (p == 0) ? rdq0[0] : rdq1[0];
      if (e.cyc <= cyc) begin
        chk($sformatf("ovalid%0d_missing", p), 0, 1);
        if (p == 0) void'(rdq0.pop_front());
        else void'(rdq1.pop_front());
      end
    end
  endtask

  // monitor: pops expectations whenever the DUT presents an output
  always @(negedge clk) begin
    cmd_t c;
    if (!rst) begin
      if (bus.ovalid0 && bus.ovalid1) chk("both_valid", 1, 0);
      mon_rd(0, bus.ovalid0, bus.odata0);
      mon_rd(1, bus.ovalid1, bus.odata1);
      if (bus.oram_en) begin
        if (cmdq.size() == 0) begin
          chk("cmd_unexpected", 1, 0);
        end else begin
          c = cmdq.pop_front();
          chk("cmd_cycle", cyc, c.cyc);
          chk("oram_we", bus.oram_we, c.we);
          chk("oram_addr", bus.oram_addr, c.addr);
          if (c.we) chk("oram_data", bus.oram_data, c.data);
        end
      end else begin
        chk("oram_we_idle", bus.oram_we, 0);
        if (cmdq.size() > 0 && cmdq[0].cyc <= cyc) begin
          chk("cmd_missing", 0, 1);
          void'(cmdq.pop_front());
        end
      end
    end
  end

  function automatic bit idle_all();
    return pend0.size() == 0 && pend1.size() == 0 &&
           !r_req[0] && !r_req[1] &&
           rdq0.size() == 0 && rdq1.size() == 0 &&
           cmdq.size() == 0;
  endfunction

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #3;
      if (idle_all()) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain_done", ok, 1);
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_ogrant0"}, bus.ogrant0, 0);
    chk({tag, "_ogrant1"}, bus.ogrant1, 0);
    chk({tag, "_ovalid0"}, bus.ovalid0, 0);
    chk({tag, "_ovalid1"}, bus.ovalid1, 0);
    chk({tag, "_odata0"}, bus.odata0, 0);
    chk({tag, "_odata1"}, bus.odata1, 0);
    chk({tag, "_oram_en"}, bus.oram_en, 0);
    chk({tag, "_oram_we"}, bus.oram_we, 0);
    chk({tag, "_oram_addr"}, bus.oram_addr, 0);
    chk({tag, "_oram_data"}, bus.oram_data, 0);
    chk({tag, "_ostarve"}, bus.ostarve, 0);
  endtask

  task automatic reset_mid();
    bit seen = 1'b0;
    push_op(0, mk(0, 0, 5, 0, 0));
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #3;
      if (gl[0]) begin
        seen = 1'b1;
        break;
      end
    end
    chk("rst_read_granted", seen, 1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk_all_zero("rst_mid");
    pend0.delete();
    pend1.delete();
    rdq0.delete();
    rdq1.delete();
    cmdq.delete();
    r_req[0] = 1'b0;
    r_req[1] = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    drain();
    push_op(0, mk(0, 0, 5, 0, 0));
    drain();
  endtask

  initial begin
    logic [3:0] v;
    for (int i = 0; i < 1024; i++) begin
      v = 4'($urandom);
      ram[i]   = v;
      mem_m[i] = v;
    end
    ram[5]      = 4'hA;
    mem_m[5]    = 4'hA;
    ram[1023]   = 4'h5;
    mem_m[1023] = 4'h5;

    #3;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;

    // single reads on each port
    push_op(0, mk(0, 0, 'h005, 0, 0));
    drain();
    push_op(1, mk(0, 0, 'h3FF, 0, 0));
    drain();

    // port 1 write then immediate read-back
    push_op(1, mk(0, 1, 'h010, 7, 0));
    push_op(1, mk(0, 0, 'h010, 0, 0));
    drain();

    // interleaved reads: port 0 then port 1 a cycle later
    push_op(0, mk(0, 0, 'h020, 0, 0));
    push_op(1, mk(1, 0, 0, 0, 0));
    push_op(1, mk(0, 0, 'h005, 0, 0));
    drain();

    // continuous contention: starvation override every 5 cycles
    pct[0] = 100;
    pct[1] = 100;
    rnd_on = 1'b1;
    repeat (22) @(posedge clk);
    rnd_on = 1'b0;
    drain();

    // counter clear: 3 denials, drop 1 cycle, re-request with port 0
    for (int i = 0; i < 14; i++)
      push_op(0, mk(0, 0, 32 + i, 0, 0));
    push_op(1, mk(0, 0, 'h040, 0, 3));
    push_op(1, mk(1, 0, 0, 0, 0));
    push_op(1, mk(0, 0, 'h041, 0, 0));
    drain();

    reset_mid();

    // randomized traffic with mixed load
    for (int k = 0; k < 4; k++) begin
      pct[0] = $urandom_range(100);
      pct[1] = $urandom_range(100);
      rnd_on = 1'b1;
      repeat (150) @(posedge clk);
      rnd_on = 1'b0;
      drain();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/sd_buf_arb.md
Name: sd_buf_arb

Overview:
- Arbiter and sequencer for the single-port block buffer RAM. The buffer holds one 512-byte SD block as 1024 x 4-bit nibbles.
- Two requesters share the RAM:
  - port 0: SD DAT engine, which has bus-timing priority;
  - port 1: OTP XOR/generation engine.
- Grants one access per cycle, registers the RAM command, and routes read data back to the owning requester with a fixed latency.
- Includes a starvation guard so port 1 always makes progress during long DAT bursts.

Parameters:
- AW, 10, RAM address width (nibble address).
- DW, 4, RAM data width.
- MAX_WAIT, 4, number of consecutive denied cycles for port 1 before it is forced to win; legal range 1..15.

Ports:
- iclk  in  1  clock
- irst  in  1  reset, asynchronous, active-high
- ireq0  in  1  port 0 access request, held until granted
- iwe0  in  1  port 0 write enable (1 = write, 0 = read)
- iaddr0  in  AW  port 0 address
- idata0  in  DW  port 0 write data
- ogrant0  out  1  port 0 request accepted this cycle (combinational)
- odata0  out  DW  port 0 read data
- ovalid0  out  1  odata0 valid, single-cycle pulse
- ireq1, iwe1, iaddr1, idata1, ogrant1, odata1, ovalid1: same as port 0, for port 1
- oram_en  out  1  RAM enable (registered)
- oram_we  out  1  RAM write enable (registered)
- oram_addr  out  AW  RAM address (registered)
- oram_data  out  DW  RAM write data (registered)
- iram_data  in  DW  RAM read data; synchronous RAM, valid 1 cycle after oram_en
- ostarve  out  1  pulse: port 1 won by starvation override this cycle (registered)

Behaviour:
- Reset values: all outputs 0. Wait counter, tag pipeline and RAM command registers are cleared.
- Requester contract:
  - hold ireqN, iweN, iaddrN and idataN stable until ograntN=1;
  - a new request may be presented in the cycle after the grant.
- Grant logic, evaluated every cycle:
  - if ireq1 and wait_cnt==MAX_WAIT: ogrant1=1, ogrant0=0;
  - else if ireq0: ogrant0=1;
  - else if ireq1: ogrant1=1.
  - At most one grant per cycle.
- Wait counter (4 bits):
  - cleared when ireq1=0 or ogrant1=1;
  - incremented when ireq1=1 and ogrant1=0;
  - saturates at MAX_WAIT.
- ostarve: registered 1-cycle pulse in the cycle after an override grant. No pulse if port 1 would have won anyway (ireq0=0).
- Command register: on any grant, the next clock edge loads oram_en=1 and oram_we/addr/data from the granted port. With no grant, oram_en=0; oram_we=0; addr and data hold their values.
- Tag pipeline:
  - 2-stage shift of {valid_rd, id}; valid_rd = grant & ~we.
  - Read granted in cycle N: RAM command in N+1, iram_data in N+2, and ovalid_id=1 with odata_id=iram_data in N+2.
  - The other port's ovalid is 0 that cycle.
  - odataN is valid only while ovalidN=1; it may be 0 or hold otherwise.
- Writes produce no ovalid. Write data reaches RAM at N+1.
- Throughput: one access per cycle, fully pipelined. Back-to-back reads from alternating ports return in grant order.
- Read-after-write to the same address issued in consecutive cycles returns the new data. RAM ordering guarantees this; the arbiter must not reorder.
- Simultaneous events: ireq0 and ireq1 in the same cycle with the counter below MAX_WAIT means port 0 wins and the counter increments.
- Reset mid-operation: in-flight reads are dropped, no ovalid after reset deasserts, counter returns to 0.

Test Plan:
- Single reads: ireq0 read addr 0x005, RAM preloaded with 0xA at that address. Required: ogrant0 in cycle 0, oram_en/oram_addr=0x005 in cycle 1, ovalid0=1 and odata0=0xA in cycle 2. Repeat for port 1 at addr 0x3FF.
- Contention with MAX_WAIT=4: ireq0 and ireq1 held continuously. Required: port 0 granted cycles 0-3; port 1 granted cycle 4 with ostarve=1 in cycle 5; port 0 granted cycle 5. Pattern repeats every 5 cycles once port 1 re-requests.
- Write then read: port 1 writes 0x7 to 0x010 in cycle 0 and reads 0x010 in cycle 1. Required: ovalid1 in cycle 3 with odata1=0x7; no ovalid in cycles 1-2.
- Interleaved reads: port 0 read in cycle 0, then port 1 read in cycle 1 with ireq0 low. Required: ovalid0 in cycle 2, ovalid1 in cycle 3, never both asserted in one cycle.
- Reset mid-flight: assert irst asynchronously one cycle after a read grant. Required: all outputs 0 immediately, no ovalid after release, and a subsequent fresh request is served normally.
- Counter clear: port 1 denied 3 cycles, drops ireq1 for 1 cycle, then re-requests together with ireq0. Required: no override until 4 further denied cycles.
